// File: rtl/lcg_stim_engine.sv
// ============================================================================
// Module   : lcg_stim_engine
// Purpose  : Stimulus/response engine. Drives a wide stimulus vector into a
//            device under test from one of four pattern generators (LCG,
//            hold, walking-one, all-zero) for a programmed number of cycles,
//            then keeps capturing responses for a fixed drain window while
//            compacting every response into a 32-bit rotating-XOR signature.
// Ports    : clk        - clock, rising edge active
//            rst_n      - asynchronous active-low reset
//            start      - run request, honoured only in IDLE or DONE
//            mode       - pattern select, latched at start
//                         (0 LCG, 1 hold, 2 walking-one, 3 all-zero)
//            seed       - LCG seed, latched at start
//            cycles     - number of RUN vectors, latched at start
//            stim_flat  - stimulus vector (IN_W bits)
//            stim_valid - stim_flat is live (PRIME or RUN)
//            resp_flat  - response vector (OUT_W bits)
//            busy       - high in PRIME, RUN and DRAIN
//            done       - high in DONE
//            cyc_count  - RUN vectors issued so far (saturating)
//            signature  - response compaction result
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcg_stim_engine #(
  parameter int IN_W      = 136,
  parameter int OUT_W     = 159,
  parameter int DRAIN_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [31:0]      seed,
  input  logic [31:0]      cycles,
  output logic [IN_W-1:0]  stim_flat,
  output logic             stim_valid,
  input  logic [OUT_W-1:0] resp_flat,
  output logic             busy,
  output logic             done,
  output logic [31:0]      cyc_count,
  output logic [31:0]      signature
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int NCH  = (IN_W + 31) / 32;   // stimulus chunks per refill
  localparam int NRCH = (OUT_W + 31) / 32;  // response chunks folded

  localparam logic [31:0] LCG_A = 32'h41C6_4E6D;
  localparam logic [31:0] LCG_C = 32'h0000_3039;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRIME = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] M_LCG  = 2'd0;
  localparam logic [1:0] M_HOLD = 2'd1;
  localparam logic [1:0] M_WALK = 2'd2;
  localparam logic [1:0] M_ZERO = 2'd3;

  localparam logic [3:0]      DRAIN_LAST = 4'((DRAIN_LAT > 0) ? (DRAIN_LAT - 1) : 0);
  localparam logic [IN_W-1:0] WALK_FIRST = IN_W'(1);

  // Jump-ahead coefficients: n LCG steps from s equal (MUL_n * s + ADD_n).
  // Every chunk of a refill is then one multiply-add off the same source
  // value instead of a serial chain of NCH multipliers.
  function automatic logic [31:0] jump_mul(input int n);
    logic [31:0] m;
    m = 32'd1;
    for (int i = 0; i < n; i++) begin
      m = m * LCG_A;
    end
    return m;
  endfunction

  function automatic logic [31:0] jump_add(input int n);
    logic [31:0] c;
    c = 32'd0;
    for (int i = 0; i < n; i++) begin
      c = c * LCG_A + LCG_C;
    end
    return c;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [2:0]      state_q,  state_d;
  logic [1:0]      mode_q,   mode_d;
  logic [31:0]     cycles_q, cycles_d;
  logic [31:0]     lcg_q,    lcg_d;
  logic [IN_W-1:0] stim_q,   stim_d;
  logic [31:0]     cyc_q,    cyc_d;
  logic [31:0]     sig_q,    sig_d;
  logic [3:0]      drain_q,  drain_d;

  // --------------------------------------------------------------------------
  // Vector generation
  // --------------------------------------------------------------------------
  // A start (from IDLE or DONE) loads the PRIME vector straight from the
  // input seed/mode; every later load works from the registered copies.
  logic            w_from_rest;
  logic [31:0]     w_lcg_src;
  logic [1:0]      w_mode_sel;
  logic [31:0]     chunk_val [NCH];
  logic [IN_W-1:0] w_refill;
  logic [31:0]     w_refill_last;
  logic [IN_W-1:0] w_walk_next;
  logic [IN_W-1:0] w_load_vec;
  logic            w_load_steps;

  assign w_from_rest   = (state_q == S_IDLE) || (state_q == S_DONE);
  assign w_lcg_src     = w_from_rest ? seed : lcg_q;
  assign w_mode_sel    = w_from_rest ? mode : mode_q;
  assign w_refill_last = chunk_val[NCH-1];

  for (genvar k = 0; k < NCH; k++) begin : g_chunk
    localparam logic [31:0] K_MUL = jump_mul(k + 1);
    localparam logic [31:0] K_ADD = jump_add(k + 1);

    assign chunk_val[k] = K_MUL * w_lcg_src + K_ADD;

    if (32 * (k + 1) <= IN_W) begin : g_full
      assign w_refill[32*k +: 32] = chunk_val[k];
    end else begin : g_part
      // Partial top chunk keeps the low bits of its LCG value.
      assign w_refill[IN_W-1:32*k] = chunk_val[k][IN_W-32*k-1:0];
    end
  end

  // Walking-one advances by rotating the current one-hot vector, which
  // gives bit index (vectors issued) mod IN_W without a separate counter.
  if (IN_W == 1) begin : g_walk_single
    assign w_walk_next = stim_q;
  end else begin : g_walk_rot
    assign w_walk_next = {stim_q[IN_W-2:0], stim_q[IN_W-1]};
  end

  always_comb begin
    w_load_vec   = '0;
    w_load_steps = 1'b0;
    case (w_mode_sel)
      M_LCG: begin
        w_load_vec   = w_refill;
        w_load_steps = 1'b1;
      end
      M_HOLD: begin
        // Only the PRIME vector is generated; RUN keeps presenting it.
        if (w_from_rest) begin
          w_load_vec   = w_refill;
          w_load_steps = 1'b1;
        end else begin
          w_load_vec = stim_q;
        end
      end
      M_WALK: begin
        w_load_vec = w_from_rest ? WALK_FIRST : w_walk_next;
      end
      M_ZERO: begin
        w_load_vec = '0;
      end
      default: begin
        w_load_vec = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Response compaction
  // --------------------------------------------------------------------------
  logic [31:0] resp_chunk [NRCH];
  logic [31:0] w_fold;
  logic [31:0] w_sig_step;

  for (genvar r = 0; r < NRCH; r++) begin : g_rchunk
    if (32 * (r + 1) <= OUT_W) begin : g_full
      assign resp_chunk[r] = resp_flat[32*r +: 32];
    end else begin : g_part
      assign resp_chunk[r] = {{(32*(r+1)-OUT_W){1'b0}}, resp_flat[OUT_W-1:32*r]};
    end
  end

  always_comb begin
    w_fold = '0;
    for (int i = 0; i < NRCH; i++) begin
      w_fold = w_fold ^ resp_chunk[i];
    end
  end

  assign w_sig_step = {sig_q[30:0], sig_q[31]} ^ w_fold;

  // --------------------------------------------------------------------------
  // Control
  // --------------------------------------------------------------------------
  logic [31:0] w_cyc_inc;

  assign w_cyc_inc = (cyc_q == 32'hFFFF_FFFF) ? cyc_q : (cyc_q + 32'd1);

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    cycles_d = cycles_q;
    lcg_d    = lcg_q;
    stim_d   = stim_q;
    cyc_d    = cyc_q;
    sig_d    = sig_q;
    drain_d  = drain_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mode_d   = mode;
          cycles_d = cycles;
          cyc_d    = '0;
          sig_d    = 32'hFFFF_FFFF;
          // The LCG is seeded and the PRIME vector drawn from it on the same
          // edge, so the state lands on the last value of that refill.
          lcg_d    = w_load_steps ? w_refill_last : seed;
          stim_d   = w_load_vec;
          state_d  = S_PRIME;
        end
      end

      S_PRIME: begin
        if (cycles_q != '0) begin
          state_d = S_RUN;
          stim_d  = w_load_vec;
          cyc_d   = w_cyc_inc;
          if (w_load_steps) begin
            lcg_d = w_refill_last;
          end
        end else if (DRAIN_LAT == 0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
          drain_d = '0;
        end
      end

      S_RUN: begin
        sig_d = w_sig_step;
        // cyc_q counts the vector on display now, so equality means the
        // last RUN vector has been presented.
        if (cyc_q == cycles_q) begin
          if (DRAIN_LAT == 0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DRAIN;
            drain_d = '0;
          end
        end else begin
          stim_d = w_load_vec;
          cyc_d  = w_cyc_inc;
          if (w_load_steps) begin
            lcg_d = w_refill_last;
          end
        end
      end

      S_DRAIN: begin
        sig_d = w_sig_step;
        if (drain_q == DRAIN_LAST) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + 4'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mode_q   <= '0;
      cycles_q <= '0;
      lcg_q    <= '0;
      stim_q   <= '0;
      cyc_q    <= '0;
      sig_q    <= '0;
      drain_q  <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      cycles_q <= cycles_d;
      lcg_q    <= lcg_d;
      stim_q   <= stim_d;
      cyc_q    <= cyc_d;
      sig_q    <= sig_d;
      drain_q  <= drain_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign stim_flat  = stim_q;
  assign stim_valid = (state_q == S_PRIME) || (state_q == S_RUN);
  assign busy       = (state_q == S_PRIME) || (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign cyc_count  = cyc_q;
  assign signature  = sig_q;

endmodule

`default_nettype wire

// File: tb/tb_lcg_stim_engine.sv
// ============================================================================
// Module   : tb_lcg_stim_engine
// Purpose  : Self-checking bench for lcg_stim_engine. A run-level model
//            predicts the vector list and signature of each run; a negedge
//            compare process checks every cycle against it, and directed
//            literal expectations pin the model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcg_stim_engine;

  localparam int IN_W      = 136;
  localparam int OUT_W     = 159;
  localparam int DRAIN_LAT = 2;
  localparam int NCH       = (IN_W + 31) / 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [1:0]       mode;
  logic [31:0]      seed;
  logic [31:0]      cycles;
  logic [IN_W-1:0]  stim_flat;
  logic             stim_valid;
  logic [OUT_W-1:0] resp_flat;
  logic             busy;
  logic             done;
  logic [31:0]      cyc_count;
  logic [31:0]      signature;

  lcg_stim_engine #(
    .IN_W      (IN_W),
    .OUT_W     (OUT_W),
    .DRAIN_LAT (DRAIN_LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .seed       (seed),
    .cycles     (cycles),
    .stim_flat  (stim_flat),
    .stim_valid (stim_valid),
    .resp_flat  (resp_flat),
    .busy       (busy),
    .done       (done),
    .cyc_count  (cyc_count),
    .signature  (signature)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state shared between the driver and the compare process.
  bit              armed = 1'b0;
  int              k;
  int              done_k;
  int              exp_c;
  int              resp_kind = 0;
  logic [31:0]     exp_sig;
  logic [31:0]     m_lcg;
  logic [IN_W-1:0] exp_vec [$];
  logic [159:0]    rnd;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (k=%0d): got %h expected %h", nm, k, act, exp);
    end
  endtask

  task automatic chkv(input string nm, input logic [IN_W-1:0] act, input logic [IN_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (k=%0d): got %h expected %h", nm, k, act, exp);
    end
  endtask

  // One full LCG refill: a fresh 32-bit value per chunk, low chunk first.
  function automatic logic [IN_W-1:0] lcg_vector();
    logic [NCH*32-1:0] t;
    t = '0;
    for (int j = 0; j < NCH; j++) begin
      m_lcg = m_lcg * 32'h41C64E6D + 32'h00003039;
      t[j*32 +: 32] = m_lcg;
    end
    return t[IN_W-1:0];
  endfunction

  // Signature step: bit i of the response lands on fold bit (i mod 32).
  function automatic logic [31:0] sig_step(input logic [31:0] s, input logic [OUT_W-1:0] r);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < OUT_W; i++) begin
      f[i % 32] = f[i % 32] ^ r[i];
    end
    return {s[30:0], s[31]} ^ f;
  endfunction

  // Response source, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (resp_kind)
      0:       resp_flat = '0;
      1: begin
        rnd       = {$urandom, $urandom, $urandom, $urandom, $urandom};
        resp_flat = rnd[OUT_W-1:0];
      end
      default: resp_flat = '1;
    endcase
  end

  // Compare process: timeline index k counts cycles since the start edge.
  logic [IN_W-1:0] e_vec;
  logic            e_v, e_b, e_d;
  logic [31:0]     e_cyc;

  always @(negedge clk) begin
    if (!armed) begin
      k       = 0;
      done_k  = -1;
      exp_sig = 32'hFFFFFFFF;
    end else begin
      if (k <= exp_c) begin
        e_vec = exp_vec[k];      e_v = 1'b1; e_b = 1'b1; e_d = 1'b0; e_cyc = 32'(k);
      end else if (k <= exp_c + DRAIN_LAT) begin
        e_vec = exp_vec[exp_c];  e_v = 1'b0; e_b = 1'b1; e_d = 1'b0; e_cyc = 32'(exp_c);
      end else begin
        e_vec = exp_vec[exp_c];  e_v = 1'b0; e_b = 1'b0; e_d = 1'b1; e_cyc = 32'(exp_c);
      end
      chkv ("stim_flat",  stim_flat, e_vec);
      chk32("stim_valid", 32'(stim_valid), 32'(e_v));
      chk32("busy",       32'(busy), 32'(e_b));
      chk32("done",       32'(done), 32'(e_d));
      chk32("cyc_count",  cyc_count, e_cyc);
      chk32("signature",  signature, exp_sig);
      if (done && done_k < 0) done_k = k;
      if (k >= 1 && k <= exp_c + DRAIN_LAT) exp_sig = sig_step(exp_sig, resp_flat);
      k = k + 1;
    end
  end

  task automatic check_all_zero(input string tag);
    chkv (tag, stim_flat, '0);
    chk32({tag, "_valid"}, 32'(stim_valid), 32'd0);
    chk32({tag, "_busy"},  32'(busy), 32'd0);
    chk32({tag, "_done"},  32'(done), 32'd0);
    chk32({tag, "_cyc"},   cyc_count, 32'd0);
    chk32({tag, "_sig"},   signature, 32'd0);
  endtask

  // Called just after a rising edge. pin selects literal expectations.
  task automatic run_test(input logic [1:0] md, input logic [31:0] sd, input int c,
                          input int rk, input int pin, input int inj, input int abort_at);
    int guard;
    logic [IN_W-1:0] v;
    exp_vec.delete();
    m_lcg = sd;
    for (int n = 0; n <= c; n++) begin
      case (md)
        2'd0: v = lcg_vector();
        2'd1: v = (n == 0) ? lcg_vector() : exp_vec[0];
        2'd2: begin v = '0; v[n % IN_W] = 1'b1; end
        default: v = '0;
      endcase
      exp_vec.push_back(v);
    end
    exp_c     = c;
    resp_kind = rk;
    mode      = md;
    seed      = sd;
    cycles    = 32'(c);
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    armed = 1'b1;
    if (pin == 1) begin
      chk32("prime_chunk0", stim_flat[31:0],  32'h00003039);
      chk32("prime_chunk1", stim_flat[63:32], 32'hD3DC167E);
      chk32("prime_valid",  32'(stim_valid),  32'd1);
    end
    guard = 0;
    while (k <= c + DRAIN_LAT + 2 && guard < c + DRAIN_LAT + 20) begin
      if (pin == 2 && k <= 3) begin
        case (k)
          0: chk32("walk_bits", 32'(stim_flat[3:0]), 32'h1);
          1: chk32("walk_bits", 32'(stim_flat[3:0]), 32'h2);
          2: chk32("walk_bits", 32'(stim_flat[3:0]), 32'h4);
          default: chk32("walk_bits", 32'(stim_flat[3:0]), 32'h8);
        endcase
      end
      if (pin == 4 && k >= 1 && k <= 5) chk32("hold_chunk0", stim_flat[31:0], 32'h00003039);
      if (k == abort_at) begin
        armed = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check_all_zero("idle_after_reset");
        return;
      end
      start = (k == inj);
      @(posedge clk); #1;
      start = 1'b0;
      guard++;
    end
    if (guard >= c + DRAIN_LAT + 20) begin
      n_cmp++;
      n_bad++;
      $display("FAIL run_timeout: got k=%0d expected more than %0d", k, c + DRAIN_LAT + 2);
    end
    if (pin == 1) begin
      chk32("t1_done_cycle", 32'(done_k), 32'd7);
      chk32("t1_cyc_count",  cyc_count,   32'd4);
    end
    if (pin == 3) begin
      chk32("c0_done_cycle", 32'(done_k), 32'd3);
      chk32("c0_signature",  signature,   32'h7FFFFFFE);
    end
    if (pin == 5) chk32("zero_resp_sig",   signature, 32'hFFFFFFFF);
    if (pin == 6) chk32("ignored_start_cyc", cyc_count, 32'd6);
    armed = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    mode   = '0;
    seed   = '0;
    cycles = '0;
    #1 check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_test(2'd0, 32'h0000_0000,   4, 1, 1, -1, -1);  // LCG, seed 0
    run_test(2'd2, 32'h1111_2222,   3, 1, 2, -1, -1);  // walking-one
    run_test(2'd0, 32'hDEAD_BEEF,   0, 2, 3, -1, -1);  // zero cycles
    run_test(2'd0, 32'h0000_0005,   1, 0, 5, -1, -1);  // resp tied low
    run_test(2'd0, 32'h0000_1234,   6, 1, 6,  2, -1);  // start in RUN
    run_test(2'd1, 32'h0000_0000,   5, 1, 4, -1, -1);  // hold
    run_test(2'd3, 32'hCAFE_F00D,   2, 1, 0, -1, -1);  // all-zero
    run_test(2'd0, 32'h0BAD_CAFE,  10, 1, 0, -1,  3);  // reset mid-RUN
    run_test(2'd2, 32'h0000_0000, 140, 1, 0, -1, -1);  // walk wraps IN_W
    run_test(2'd0, 32'h8765_4321,   3, 1, 0, -1, -1);  // LCG after wrap run

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
